// File: rtl/led_fx_pkg.sv
// led_fx_pkg: effect encodings, FSM states and constants shared by the LED effects controller.
package led_fx_pkg;
  localparam logic [1:0] FX_ROT_R = 2'b00;
  localparam logic [1:0] FX_ROT_L = 2'b01;
  localparam logic [1:0] FX_PING  = 2'b10;
  localparam logic [1:0] FX_BAR   = 2'b11;
  typedef enum logic [2:0] {
    ST_ROT_R,
    ST_ROT_L,
    ST_PING_R,
    ST_PING_L,
    ST_BAR_FILL,
    ST_BAR_DRAIN
  } fx_state_t;
  localparam logic [3:0] SPEED_MUL [4] = '{4'd1, 4'd2, 4'd4, 4'd8};
  localparam logic [7:0] LED_RST_PATTERN = 8'b1000_0000;
  function automatic logic [1:0] fx_of(fx_state_t s);
    return (s == ST_ROT_R) ? FX_ROT_R :
           (s == ST_ROT_L) ? FX_ROT_L :
           (s == ST_PING_R || s == ST_PING_L) ? FX_PING : FX_BAR;
  endfunction
  function automatic fx_state_t fx_entry(logic [1:0] fx);
    return (fx == FX_ROT_R) ? ST_ROT_R :
           (fx == FX_ROT_L) ? ST_ROT_L :
           (fx == FX_PING) ? ST_PING_R : ST_BAR_FILL;
  endfunction
endpackage

// File: rtl/led_fx_ctrl_tick.sv
// led_tick_gen: prescaler emitting a one-cycle tick every BASE_DIV*{1,2,4,8} enabled cycles.
module led_tick_gen #(
  parameter int BASE_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       en,
  input  logic       restart,
  output logic       tick
);
  import led_fx_pkg::*;
  localparam int CW = $clog2(BASE_DIV * 8);
  logic [CW-1:0] cnt, last;
  assign last = CW'(BASE_DIV * int'(SPEED_MUL[sel]) - 1);
  assign tick = en && !restart && cnt == last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (restart) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/led_fx_ctrl.sv
// led_fx_ctrl: LED effect sequencer driving an external 8-bit shift datapath (step/lr/s_in) with a pattern shadow.
module led_fx_ctrl #(
  parameter int BASE_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] sw,
  output logic       step,
  output logic       lr,
  output logic       s_in,
  output logic [7:0] pattern
);
  import led_fx_pkg::*;
  logic [3:0] sw_m, sw_s;
  logic [1:0] speed_q;
  logic [7:0] nxt;
  logic       restart, empty;
  fx_state_t  state, cur, nst;
  assign restart = sw_s[3:2] != speed_q;
  led_tick_gen #(.BASE_DIV(BASE_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .sel(sw_s[3:2]),
    .en(en),
    .restart(restart),
    .tick(step)
  );
  // A new effect is entered at its start state but shifts on from the current pattern.
  always_comb begin
    cur = (fx_of(state) == sw_s[1:0]) ? state : fx_entry(sw_s[1:0]);
    empty = pattern == 8'h00 && sw_s[1:0] != FX_BAR;
    lr = cur != ST_ROT_L && cur != ST_PING_L;
    s_in = empty || (cur == ST_ROT_R && pattern[0]) || (cur == ST_ROT_L && pattern[7]) || cur == ST_BAR_FILL;
    nxt = lr ? {s_in, pattern[7:1]} : {pattern[6:0], s_in};
    nst = (fx_of(cur) == FX_PING) ? (nxt[0] ? ST_PING_L : nxt[7] ? ST_PING_R : cur) :
          (fx_of(cur) == FX_BAR) ? (nxt == 8'hFF ? ST_BAR_DRAIN : nxt == 8'h00 ? ST_BAR_FILL : cur) : cur;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sw_m <= '0;
      sw_s <= '0;
      speed_q <= '0;
      state <= ST_ROT_R;
      pattern <= LED_RST_PATTERN;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
      speed_q <= sw_s[3:2];
      if (step) begin
        state <= nst;
        pattern <= nxt;
      end
    end
endmodule

// File: tb/tb_led_fx_ctrl.sv
// tb_led_fx_ctrl: directed bench for led_fx_ctrl (BASE_DIV=4) with a per-cycle behavioural reference model.
module tb_led_fx_ctrl;
  logic       clk = 0, reset = 1, en = 1;
  logic [3:0] sw = 4'b0000;
  logic       step, lr, s_in;
  logic [7:0] pattern;
  int n_chk = 0, n_fail = 0;
  logic stp_lr, stp_sin;

  led_fx_ctrl #(.BASE_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .sw(sw),
    .step(step), .lr(lr), .s_in(s_in), .pattern(pattern)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: sw is seen two cycles late, the step period is 4<<speed,
  // and the effect rules are applied directly to the 8-bit pattern value.
  int         m_cnt, e_per;
  logic [7:0] m_pat, np;
  logic       m_dir, m_fill, d, f, e_lr, e_sin, e_step, e_rst;
  logic [1:0] m_last, m_pspd, e_eff, e_spd;
  logic [3:0] m_s1, m_s2;

  always @(negedge clk) begin
    if (!reset) begin
      m_cnt = 0; m_pat = 8'h80; m_dir = 1; m_fill = 1; m_last = 0;
      m_s1 = 0; m_s2 = 0; m_pspd = 0;
      chk("model_rst_step", step, 0);
      chk("model_rst_pattern", pattern, 8'h80);
    end else begin
      e_eff = m_s2[1:0];
      e_spd = m_s2[3:2];
      d = (e_eff != m_last) ? 1'b1 : m_dir;
      f = (e_eff != m_last) ? 1'b1 : m_fill;
      e_lr = (e_eff == 2'd1) ? 1'b0 : (e_eff == 2'd2) ? d : 1'b1;
      e_sin = (e_eff == 2'd0) ? m_pat[0] : (e_eff == 2'd1) ? m_pat[7] : (e_eff == 2'd2) ? 1'b0 : f;
      if (e_eff != 2'd3 && m_pat == 8'h00) e_sin = 1'b1;
      e_per = 4 << e_spd;
      e_rst = e_spd != m_pspd;
      e_step = en && !e_rst && m_cnt == e_per - 1;
      chk("model_step", step, e_step);
      chk("model_pattern", pattern, m_pat);
      if (e_step) begin
        chk("model_lr", lr, e_lr);
        chk("model_s_in", s_in, e_sin);
        np = e_lr ? {e_sin, m_pat[7:1]} : {m_pat[6:0], e_sin};
        if (e_eff == 2'd2) d = np[0] ? 1'b0 : np[7] ? 1'b1 : d;
        if (e_eff == 2'd3) f = (np == 8'hFF) ? 1'b0 : (np == 8'h00) ? 1'b1 : f;
        m_pat = np; m_dir = d; m_fill = f; m_last = e_eff;
      end
      m_cnt = e_rst ? 0 : !en ? m_cnt : e_step ? 0 : m_cnt + 1;
      m_pspd = e_spd;
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end

  // Called just after a rising edge; counts cycles until step is seen, then lets it take effect.
  task automatic wait_step(input string name, input int exp_gap);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < 300);
    chk({name, "_gap"}, n, exp_gap);
    stp_lr = lr;
    stp_sin = s_in;
    @(posedge clk); #1;
  endtask

  logic [7:0] t_rot  [8]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
  logic [7:0] t_ping [16] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                              8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};
  logic [7:0] t_bar  [15] = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h7F,
                              8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

  initial begin
    #2 reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pattern", pattern, 8'h80);
    chk("reset_step", step, 0);
    reset = 1;
    for (int i = 0; i < 8; i++) begin
      wait_step("rot_r", 4);
      chk("rot_r_pattern", pattern, t_rot[i]);
      chk("rot_r_lr", stp_lr, 1);
    end
    sw = 4'b0010;
    for (int i = 0; i < 16; i++) begin
      wait_step("ping", 4);
      chk("ping_pattern", pattern, t_ping[i]);
      chk("ping_s_in", stp_sin, 0);
    end
    reset = 0;
    sw = 4'b0011;
    @(posedge clk); #1;
    chk("bar_reset_pattern", pattern, 8'h80);
    reset = 1;
    for (int i = 0; i < 15; i++) begin
      wait_step("bar", 4);
      chk("bar_pattern", pattern, t_bar[i]);
      chk("bar_lr", stp_lr, 1);
    end
    sw = 4'b0000;
    wait_step("recover", 4);
    chk("recover_s_in", stp_sin, 1);
    chk("recover_pattern", pattern, 8'h80);
    sw = 4'b1100;
    wait_step("slow_first", 35);
    chk("slow_first_pattern", pattern, 8'h40);
    wait_step("slow", 32);
    chk("slow_pattern", pattern, 8'h20);
    repeat (10) @(posedge clk);
    #1;
    en = 0;
    repeat (10) begin
      @(negedge clk);
      chk("en_low_step", step, 0);
      @(posedge clk); #1;
    end
    en = 1;
    wait_step("resume", 22);
    chk("resume_pattern", pattern, 8'h10);
    sw = 4'b0000;
    wait_step("fast_first", 7);
    chk("fast_first_pattern", pattern, 8'h08);
    @(posedge clk); #1;
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_reset_step", step, 0);
      chk("mid_reset_pattern", pattern, 8'h80);
      @(posedge clk); #1;
    end
    reset = 1;
    wait_step("post_reset", 4);
    chk("post_reset_pattern", pattern, 8'h40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
